pwm_capture: RTL and testbench

- Receive-side counterpart of the team's 8-bit PWM generator; it decodes an incoming PWM waveform back into an 8-bit duty command.
- Measures the high time and the period of `pwm_in` in clock cycles and checks the period against the nominal 2^PERIOD_LOG2 frame.
- On each good frame it publishes `cmd_out` with a one-cycle `cmd_valid` strobe.
- Sits on the input side of the fabric, for example reading back a PWM line from the ATmega328PB or looping back the local generator for self-test.

---
 rtl/pwm_capture.sv | 167 ++++++++++++++++
 tb/tb_pwm_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - decodes an incoming PWM waveform into an 8-bit duty command
//
// Measures high time and period of pwm_in in clk cycles. A frame is the span between
// two synchronized rising edges. Frames whose period lies within PERIOD_TOL of
// 2^PERIOD_LOG2 publish a new command; other frames raise period_err instead.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   pwm_in     PWM line, asynchronous to clk
//   cmd_out    last decoded duty command
//   cmd_valid  one-cycle pulse when cmd_out is updated from a good frame
//   period_err one-cycle pulse when a frame's period is out of tolerance
//   stuck      high while no edge has been seen for TIMEOUT_FRAMES nominal periods
module pwm_capture #(
  parameter int PERIOD_LOG2    = 10,
  parameter int PERIOD_TOL     = 4,
  parameter int TIMEOUT_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] cmd_out,
  output logic       cmd_valid,
  output logic       period_err,
  output logic       stuck
);

  localparam int CW  = PERIOD_LOG2 + 1;
  localparam int NOM = 1 << PERIOD_LOG2;
  localparam int TO  = TIMEOUT_FRAMES * NOM;
  localparam int IW  = $clog2(TO + 1);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_NOM   = CW'(NOM);
  localparam logic [CW-1:0] C_PMIN  = CW'(NOM - PERIOD_TOL);
  localparam logic [CW-1:0] C_PMAX  = CW'(NOM + PERIOD_TOL);
  localparam logic [IW-1:0] C_TO    = IW'(TO);
  localparam logic [IW-1:0] C_TO_M1 = IW'(TO - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_sync3;
  logic [CW-1:0]   r_high_cnt;
  logic [CW-1:0]   r_per_cnt;
  logic [IW-1:0]   r_idle_cnt;

  logic            w_rise;
  logic            w_fall;
  logic            w_edge;
  logic            w_timeout;
  logic            w_per_ok;
  logic [CW-1:0]   w_high_inc;
  logic [CW-1:0]   w_per_inc;
  logic [7:0]      w_decode;

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;
  assign w_edge = w_rise | w_fall;

  // Fires on the cycle idle_cnt would step onto the limit; an edge in that
  // same cycle clears the count instead, so the edge wins.
  assign w_timeout = ~w_edge & (r_idle_cnt == C_TO_M1);

  assign w_high_inc = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + C_ONE;
  assign w_per_inc  = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + C_ONE;

  assign w_per_ok = (r_per_cnt >= C_PMIN) && (r_per_cnt <= C_PMAX);

  // Top eight bits of the nominal-period range; a full-frame high time clamps to 0xFF.
  assign w_decode = (r_high_cnt >= C_NOM) ? 8'hFF : r_high_cnt[PERIOD_LOG2-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_fall) w_state_nxt = S_LOW;
      S_LOW:   if (w_rise) w_state_nxt = S_HIGH;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_idle_cnt <= '0;
      cmd_out    <= 8'h00;
      cmd_valid  <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      r_sync1    <= pwm_in;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      cmd_valid  <= 1'b0;
      period_err <= 1'b0;

      if (w_edge) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != C_TO) begin
        r_idle_cnt <= r_idle_cnt + IW'(1);
      end

      // A dead line reports its resting level as 0% or 100% duty.
      if (w_edge) begin
        stuck <= 1'b0;
      end else if (w_timeout) begin
        stuck   <= 1'b1;
        cmd_out <= {8{r_sync2}};
      end

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_high_cnt <= C_ONE;
            r_per_cnt  <= C_ONE;
          end
        end
        S_HIGH: begin
          r_per_cnt <= w_per_inc;
          if (!w_fall) begin
            r_high_cnt <= w_high_inc;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            if (w_per_ok) begin
              cmd_out   <= w_decode;
              cmd_valid <= 1'b1;
            end else begin
              period_err <= 1'b1;
            end
            r_high_cnt <= C_ONE;
            r_per_cnt  <= C_ONE;
          end else begin
            r_per_cnt <= w_per_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] cmd_out;
  logic       cmd_valid;
  logic       period_err;
  logic       stuck;

  int vectors     = 0;
  int miscompares = 0;

  int         cycle = 0;
  logic [7:0] vlog[$];
  int         vcyc[$];
  int         perr_cnt       = 0;
  int         overlap_cnt    = 0;
  int         stuck_rise_cnt = 0;
  logic       stuck_q        = 1'b0;

  pwm_capture dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .period_err(period_err),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        vlog.push_back(cmd_out);
        vcyc.push_back(cycle);
      end
      if (period_err) perr_cnt++;
      if (cmd_valid && period_err) overlap_cnt++;
      if (stuck && !stuck_q) stuck_rise_cnt++;
    end
    stuck_q = stuck;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    vlog.delete();
    vcyc.delete();
    perr_cnt       = 0;
    stuck_rise_cnt = 0;
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (cmd_out !== 8'h00) begin miscompares++; $display("FAIL rst_cmd: got %h want 00", cmd_out); end
    vectors++;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", cmd_valid); end
    vectors++;
    if (period_err !== 1'b0) begin miscompares++; $display("FAIL rst_perr: got %b want 0", period_err); end
    vectors++;
    if (stuck !== 1'b0) begin miscompares++; $display("FAIL rst_stuck: got %b want 0", stuck); end
    rst = 1'b0;
    drive(1'b0, 5);
  endtask

  task automatic test_loopback_80();
    clear_log();
    repeat (3) frame(514, 1024);
    drive(1'b1, 8);
    vectors++;
    if (vlog.size() !== 3) begin miscompares++; $display("FAIL lb80_count: got %0d want 3", vlog.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (vlog.size() <= i || vlog[i] !== 8'h80) begin
        miscompares++;
        $display("FAIL lb80_cmd[%0d]: got %h want 80", i, (vlog.size() > i) ? vlog[i] : 8'hxx);
      end
    end
    vectors++;
    if (vcyc.size() < 3 || (vcyc[2] - vcyc[1]) != 1024) begin
      miscompares++;
      $display("FAIL lb80_spacing: got %0d want 1024", (vcyc.size() >= 3) ? vcyc[2] - vcyc[1] : -1);
    end
    vectors++;
    if (cmd_out !== 8'h80) begin miscompares++; $display("FAIL lb80_out: got %h want 80", cmd_out); end
    vectors++;
    if (perr_cnt != 0) begin miscompares++; $display("FAIL lb80_perr: got %0d want 0", perr_cnt); end
    drive(1'b0, 1016);
  endtask

  task automatic test_cmd0_255();
    clear_log();
    frame(2, 1024);
    frame(1022, 1024);
    drive(1'b1, 8);
    vectors++;
    if (vlog.size() !== 3) begin miscompares++; $display("FAIL ext_count: got %0d want 3", vlog.size()); end
    vectors++;
    if (vlog.size() < 1 || vlog[0] !== 8'h02) begin miscompares++; $display("FAIL ext_h8: got %h want 02", (vlog.size() > 0) ? vlog[0] : 8'hxx); end
    vectors++;
    if (vlog.size() < 2 || vlog[1] !== 8'h00) begin miscompares++; $display("FAIL ext_cmd0: got %h want 00", (vlog.size() > 1) ? vlog[1] : 8'hxx); end
    vectors++;
    if (vlog.size() < 3 || vlog[2] !== 8'hFF) begin miscompares++; $display("FAIL ext_cmd255: got %h want ff", (vlog.size() > 2) ? vlog[2] : 8'hxx); end
    vectors++;
    if (cmd_out !== 8'hFF) begin miscompares++; $display("FAIL ext_out: got %h want ff", cmd_out); end
    vectors++;
    if (perr_cnt != 0) begin miscompares++; $display("FAIL ext_perr: got %0d want 0", perr_cnt); end
    drive(1'b0, 1016);
  endtask

  task automatic test_period_err();
    clear_log();
    frame(400, 1030);
    drive(1'b1, 8);
    vectors++;
    if (perr_cnt != 1) begin miscompares++; $display("FAIL perr_count: got %0d want 1", perr_cnt); end
    vectors++;
    if (vlog.size() !== 1) begin miscompares++; $display("FAIL perr_valid: got %0d want 1", vlog.size()); end
    vectors++;
    if (cmd_out !== 8'h02) begin miscompares++; $display("FAIL perr_hold: got %h want 02", cmd_out); end
    drive(1'b0, 1016);
  endtask

  task automatic test_stuck();
    clear_log();
    frame(514, 1024);
    drive(1'b1, 2050);
    vectors++;
    if (stuck !== 1'b0) begin miscompares++; $display("FAIL stuck_early: got %b want 0", stuck); end
    drive(1'b1, 1);
    vectors++;
    if (stuck !== 1'b1) begin miscompares++; $display("FAIL stuck_set: got %b want 1", stuck); end
    vectors++;
    if (cmd_out !== 8'hFF) begin miscompares++; $display("FAIL stuck_cmd: got %h want ff", cmd_out); end
    drive(1'b1, 949);
    vectors++;
    if (stuck !== 1'b1) begin miscompares++; $display("FAIL stuck_hold: got %b want 1", stuck); end
    drive(1'b0, 5);
    vectors++;
    if (stuck !== 1'b0) begin miscompares++; $display("FAIL stuck_clear: got %b want 0", stuck); end
    vectors++;
    if (cmd_out !== 8'hFF) begin miscompares++; $display("FAIL stuck_keep: got %h want ff", cmd_out); end
    drive(1'b0, 300);
    drive(1'b1, 8);
    vectors++;
    if (vlog.size() !== 2) begin miscompares++; $display("FAIL stuck_count: got %0d want 2", vlog.size()); end
    vectors++;
    if (vlog.size() < 2 || vlog[1] !== 8'h80) begin miscompares++; $display("FAIL stuck_last: got %h want 80", (vlog.size() > 1) ? vlog[1] : 8'hxx); end
    vectors++;
    if (perr_cnt != 0) begin miscompares++; $display("FAIL stuck_perr: got %0d want 0", perr_cnt); end
    drive(1'b0, 1016);
  endtask

  task automatic test_edge_boundary();
    clear_log();
    drive(1'b1, 2048);
    drive(1'b0, 100);
    frame(514, 1024);
    frame(514, 1024);
    drive(1'b1, 8);
    vectors++;
    if (stuck_rise_cnt != 0) begin miscompares++; $display("FAIL bnd_stuck: got %0d want 0", stuck_rise_cnt); end
    vectors++;
    if (perr_cnt != 1) begin miscompares++; $display("FAIL bnd_perr: got %0d want 1", perr_cnt); end
    vectors++;
    if (vlog.size() !== 3) begin miscompares++; $display("FAIL bnd_count: got %0d want 3", vlog.size()); end
    vectors++;
    if (vlog.size() < 3 || vlog[2] !== 8'h80) begin miscompares++; $display("FAIL bnd_cmd: got %h want 80", (vlog.size() > 2) ? vlog[2] : 8'hxx); end
    vectors++;
    if (cmd_out !== 8'h80) begin miscompares++; $display("FAIL bnd_out: got %h want 80", cmd_out); end
    drive(1'b0, 1016);
  endtask

  task automatic test_reset_mid();
    clear_log();
    frame(514, 1024);
    frame(514, 1024);
    drive(1'b1, 200);
    vectors++;
    if (cmd_out !== 8'h80) begin miscompares++; $display("FAIL rmid_pre: got %h want 80", cmd_out); end
    rst = 1'b1;
    #1;
    vectors++;
    if (cmd_out !== 8'h00) begin miscompares++; $display("FAIL rmid_cmd: got %h want 00", cmd_out); end
    vectors++;
    if ({cmd_valid, period_err, stuck} !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_flags: got %b want 000", {cmd_valid, period_err, stuck});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    drive(1'b1, 313);
    drive(1'b0, 510);
    drive(1'b1, 8);
    vectors++;
    if (vlog.size() !== 0) begin miscompares++; $display("FAIL rmid_partial: got %0d want 0", vlog.size()); end
    vectors++;
    if (cmd_out !== 8'h00) begin miscompares++; $display("FAIL rmid_hold: got %h want 00", cmd_out); end
    drive(1'b1, 506);
    drive(1'b0, 510);
    drive(1'b1, 8);
    vectors++;
    if (vlog.size() !== 1) begin miscompares++; $display("FAIL rmid_count: got %0d want 1", vlog.size()); end
    vectors++;
    if (cmd_out !== 8'h80) begin miscompares++; $display("FAIL rmid_out: got %h want 80", cmd_out); end
    drive(1'b0, 1016);
  endtask

  initial begin
    test_reset();
    test_loopback_80();
    test_cmd0_255();
    test_period_err();
    test_stuck();
    test_edge_boundary();
    test_reset_mid();
    vectors++;
    if (overlap_cnt != 0) begin miscompares++; $display("FAIL overlap: got %0d want 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
